// File: rtl/ex_wb_stage_pkg.sv
// Shared processor types: datapath widths and the EX/WB record, also consumed by WB.
// No logic of its own; the helper below is the pure EX result selection.
package proc_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  typedef struct packed {
    logic              regwrite;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } ex_wb_t;

  localparam ex_wb_t EX_WB_BUBBLE = '0;

  // Jumps write the link (PC+1); otherwise an immediate or a base+immediate.
  function automatic logic [DATA_W-1:0] ex_result(
    input logic              jump,
    input logic              value_to_reg,
    input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] op
  );
    logic [DATA_W-1:0] r;
    if (jump) begin
      r = pc + DATA_W'(1);
    end else if (value_to_reg) begin
      r = imm;
    end else begin
      r = op + imm;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// ID/EX fields into the execute stage, redirect to fetch and EX/WB write port out.
// Pure wiring; no latency, no backpressure.
interface ex_wb_stage_if;
  import proc_pkg::*;

  logic [DATA_W-1:0] PC_ID_EX;
  logic [REG_AW-1:0] RegRd_ID_EX;
  logic [REG_AW-1:0] RegRs_ID_EX;
  logic [DATA_W-1:0] imm_ID_EX;
  logic [DATA_W-1:0] relAdd_ID_EX;
  logic              RegWrite_ID_EX;
  logic              jumpIns_ID_EX;
  logic              valueToReg_ID_EX;
  logic [DATA_W-1:0] Data1_ID_EX;

  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              RegWrite_EX_WB;
  logic [REG_AW-1:0] RegRd_EX_WB;
  logic [DATA_W-1:0] Data_EX_WB;

  modport master (
    output PC_ID_EX, RegRd_ID_EX, RegRs_ID_EX, imm_ID_EX, relAdd_ID_EX,
           RegWrite_ID_EX, jumpIns_ID_EX, valueToReg_ID_EX, Data1_ID_EX,
    input  redirect_valid, redirect_pc, RegWrite_EX_WB, RegRd_EX_WB, Data_EX_WB
  );

  modport slave (
    input  PC_ID_EX, RegRd_ID_EX, RegRs_ID_EX, imm_ID_EX, relAdd_ID_EX,
           RegWrite_ID_EX, jumpIns_ID_EX, valueToReg_ID_EX, Data1_ID_EX,
    output redirect_valid, redirect_pc, RegWrite_EX_WB, RegRd_EX_WB, Data_EX_WB
  );

endinterface

// File: rtl/ex_wb_stage_squash.sv
// Wrong-path squash counter plus retired/squashed performance counters.
// State updates one cycle after a live jump; live flag is combinational; never stalls.
module ex_squash_ctrl #(
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             jump_req,
  output logic             live,
  output logic             squash_active,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);

  localparam int SQ_W = 2;

  logic [SQ_W-1:0] squash_cnt;

  assign live          = (squash_cnt == '0);
  assign squash_active = !live;

  // A jump seen while squashing is itself wrong-path, so it never reloads.
  always_ff @(posedge clk) begin
    if (Reset) begin
      squash_cnt   <= '0;
      retired_cnt  <= '0;
      squashed_cnt <= '0;
    end else if (!live) begin
      squash_cnt   <= squash_cnt - SQ_W'(1);
      squashed_cnt <= squashed_cnt + CNT_W'(1);
    end else begin
      retired_cnt <= retired_cnt + CNT_W'(1);
      if (jump_req) begin
        squash_cnt <= SQ_W'(FLUSH_SLOTS);
      end
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage and EX/WB register: result, forwarding, jump redirect and squash.
// One cycle ID/EX to EX/WB, redirect same cycle; no stall, advances every cycle.
module ex_wb_stage
  import proc_pkg::*;
#(
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  ex_wb_stage_if.slave     bus,
  output logic             squash_active,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);

  logic              live;
  logic [DATA_W-1:0] op;
  ex_wb_t            ex_wb_d;
  ex_wb_t            ex_wb_q;

  ex_squash_ctrl #(
    .FLUSH_SLOTS (FLUSH_SLOTS),
    .CNT_W       (CNT_W)
  ) u_squash (
    .clk           (clk),
    .Reset         (Reset),
    .jump_req      (bus.jumpIns_ID_EX),
    .live          (live),
    .squash_active (squash_active),
    .retired_cnt   (retired_cnt),
    .squashed_cnt  (squashed_cnt)
  );

  assign bus.redirect_valid = live & bus.jumpIns_ID_EX;
  assign bus.redirect_pc    = bus.PC_ID_EX + bus.relAdd_ID_EX;

  // Bypass the previous result when it targets this instruction's source.
  always_comb begin
    op = bus.Data1_ID_EX;
    if (ex_wb_q.regwrite && (ex_wb_q.rd == bus.RegRs_ID_EX)) begin
      op = ex_wb_q.data;
    end
  end

  always_comb begin
    ex_wb_d = EX_WB_BUBBLE;
    if (live) begin
      ex_wb_d.regwrite = bus.RegWrite_ID_EX;
      ex_wb_d.rd       = bus.RegRd_ID_EX;
      ex_wb_d.data     = ex_result(bus.jumpIns_ID_EX, bus.valueToReg_ID_EX,
                                   bus.PC_ID_EX, bus.imm_ID_EX, op);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ex_wb_q <= EX_WB_BUBBLE;
    end else begin
      ex_wb_q <= ex_wb_d;
    end
  end

  assign bus.RegWrite_EX_WB = ex_wb_q.regwrite;
  assign bus.RegRd_EX_WB    = ex_wb_q.rd;
  assign bus.Data_EX_WB     = ex_wb_q.data;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed vector table, reset-during-squash sequence, then
// random stimulus against a spec-level reference model.
module tb_ex_wb_stage;
  import proc_pkg::*;

  localparam int FLUSH = 2;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          squash_active;
  logic [CW-1:0] retired_cnt;
  logic [CW-1:0] squashed_cnt;

  ex_wb_stage_if bus ();

  ex_wb_stage #(.FLUSH_SLOTS(FLUSH), .CNT_W(CW)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .bus           (bus),
    .squash_active (squash_active),
    .retired_cnt   (retired_cnt),
    .squashed_cnt  (squashed_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc, rel, imm, d1;
    logic [2:0]  rs, rd;
    logic        we, jmp, v2r;
    logic        x_rv;
    logic [7:0]  x_rpc;
    logic        x_we;
    logic [2:0]  x_rd;
    logic [7:0]  x_data;
    logic        x_sa;
    logic [15:0] x_ret, x_sq;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: last written-back record, wrong-path slots left, counts.
  logic       m_we = 1'b0;
  logic [2:0] m_rd = '0;
  logic [7:0] m_data = '0;
  int         m_left = 0;
  int         m_ret = 0;
  int         m_sq = 0;

  vec_t tbl[10];

  function automatic vec_t mk(
    input logic [7:0] pc, rel, imm, d1, input logic [2:0] rs, rd,
    input logic we, jmp, v2r,
    input logic xrv, input logic [7:0] xrpc, input logic xwe, input logic [2:0] xrd,
    input logic [7:0] xdata, input logic xsa, input logic [15:0] xret, xsq);
    vec_t v;
    v.pc = pc; v.rel = rel; v.imm = imm; v.d1 = d1; v.rs = rs; v.rd = rd;
    v.we = we; v.jmp = jmp; v.v2r = v2r;
    v.x_rv = xrv; v.x_rpc = xrpc; v.x_we = xwe; v.x_rd = xrd; v.x_data = xdata;
    v.x_sa = xsa; v.x_ret = xret; v.x_sq = xsq;
    return v;
  endfunction

  function automatic vec_t rnd_in();
    vec_t v;
    v = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           3'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the architectural rules to one cycle and fills in the expectations.
  task automatic model(inout vec_t v, input logic rst);
    logic [7:0] op, res;
    v.x_rpc = v.pc + v.rel;
    v.x_rv  = !rst && (m_left == 0) && v.jmp;
    if (rst) begin
      m_we = 0; m_rd = 0; m_data = 0; m_left = 0; m_ret = 0; m_sq = 0;
    end else if (m_left > 0) begin
      m_we = 0; m_rd = 0; m_data = 0;
      m_left = m_left - 1;
      m_sq = (m_sq + 1) % 65536;
    end else begin
      op = (m_we && m_rd == v.rs) ? m_data : v.d1;
      if (v.jmp)      res = v.pc + 8'd1;
      else if (v.v2r) res = v.imm;
      else            res = op + v.imm;
      m_we = v.we; m_rd = v.rd; m_data = res;
      m_ret = (m_ret + 1) % 65536;
      if (v.jmp) m_left = FLUSH;
    end
    v.x_we = m_we; v.x_rd = m_rd; v.x_data = m_data;
    v.x_sa = (m_left != 0);
    v.x_ret = 16'(m_ret); v.x_sq = 16'(m_sq);
  endtask

  // Entered and left at posedge+1: drive, check redirect, clock, check registers.
  task automatic step(input vec_t v, input logic rst, input string tag);
    Reset = rst;
    bus.PC_ID_EX = v.pc; bus.relAdd_ID_EX = v.rel; bus.imm_ID_EX = v.imm;
    bus.Data1_ID_EX = v.d1; bus.RegRs_ID_EX = v.rs; bus.RegRd_ID_EX = v.rd;
    bus.RegWrite_ID_EX = v.we; bus.jumpIns_ID_EX = v.jmp; bus.valueToReg_ID_EX = v.v2r;
    #2;
    if (!rst) chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(v.x_rv));
    chk({tag, ".redirect_pc"}, 32'(bus.redirect_pc), 32'(v.x_rpc));
    @(posedge clk);
    #1;
    chk({tag, ".RegWrite_EX_WB"}, 32'(bus.RegWrite_EX_WB), 32'(v.x_we));
    chk({tag, ".RegRd_EX_WB"}, 32'(bus.RegRd_EX_WB), 32'(v.x_rd));
    chk({tag, ".Data_EX_WB"}, 32'(bus.Data_EX_WB), 32'(v.x_data));
    chk({tag, ".squash_active"}, 32'(squash_active), 32'(v.x_sa));
    chk({tag, ".retired_cnt"}, 32'(retired_cnt), 32'(v.x_ret));
    chk({tag, ".squashed_cnt"}, 32'(squashed_cnt), 32'(v.x_sq));
  endtask

  // Directed row: model kept in sync, but the table's own expectations are checked.
  task automatic run_fixed(input vec_t v, input logic rst, input string tag);
    vec_t shadow;
    shadow = v;
    model(shadow, rst);
    step(v, rst, tag);
  endtask

  initial begin
    vec_t v;

    //         pc     rel    imm    d1     rs rd we jmp v2r | rv rpc   we rd data  sa ret sq
    tbl[0] = mk(8'h10, 8'h00, 8'h5A, 8'h00, 0, 3, 1, 0, 1,  0, 8'h10, 1, 3, 8'h5A, 0, 1, 0);
    tbl[1] = mk(8'h11, 8'h00, 8'h10, 8'h00, 0, 2, 1, 0, 1,  0, 8'h11, 1, 2, 8'h10, 0, 2, 0);
    tbl[2] = mk(8'h12, 8'h00, 8'h05, 8'h00, 2, 4, 1, 0, 0,  0, 8'h12, 1, 4, 8'h15, 0, 3, 0);
    tbl[3] = mk(8'h13, 8'h00, 8'h20, 8'hF0, 5, 5, 1, 0, 0,  0, 8'h13, 1, 5, 8'h10, 0, 4, 0);
    tbl[4] = mk(8'hFE, 8'h04, 8'h00, 8'h00, 0, 7, 1, 1, 0,  1, 8'h02, 1, 7, 8'hFF, 1, 5, 0);
    tbl[5] = mk(8'h02, 8'h10, 8'h00, 8'h00, 0, 1, 1, 1, 0,  0, 8'h12, 0, 0, 8'h00, 1, 5, 1);
    tbl[6] = mk(8'h03, 8'h00, 8'hAA, 8'h00, 0, 6, 1, 0, 1,  0, 8'h03, 0, 0, 8'h00, 0, 5, 2);
    tbl[7] = mk(8'h04, 8'h00, 8'h33, 8'h00, 0, 1, 1, 0, 1,  0, 8'h04, 1, 1, 8'h33, 0, 6, 2);
    tbl[8] = mk(8'h05, 8'h00, 8'h01, 8'h01, 1, 2, 0, 0, 0,  0, 8'h05, 0, 2, 8'h34, 0, 7, 2);
    tbl[9] = mk(8'h06, 8'h00, 8'h01, 8'h07, 2, 0, 1, 0, 0,  0, 8'h06, 1, 0, 8'h08, 0, 8, 2);

    @(posedge clk);
    #1;

    // Two reset cycles with random inputs: everything registered reads zero.
    for (int i = 0; i < 2; i++) begin
      v = rnd_in();
      v.x_rpc = v.pc + v.rel;
      run_fixed(v, 1'b1, "reset");
    end

    for (int i = 0; i < 10; i++) begin
      run_fixed(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Reset one cycle into a squash window, then a normal live instruction.
    run_fixed(mk(8'h20, 8'h08, 8'h00, 8'h00, 0, 3, 0, 1, 0,
                 1, 8'h28, 0, 3, 8'h21, 1, 9, 2), 1'b0, "rst_jump");
    v = rnd_in();
    v.jmp = 1'b0;
    v = mk(v.pc, v.rel, v.imm, v.d1, v.rs, v.rd, v.we, 1'b0, v.v2r,
           0, v.pc + v.rel, 0, 0, 8'h00, 0, 0, 0);
    run_fixed(v, 1'b1, "rst_mid_squash");
    run_fixed(mk(8'h30, 8'h01, 8'h77, 8'h00, 0, 6, 1, 0, 1,
                 0, 8'h31, 1, 6, 8'h77, 0, 1, 0), 1'b0, "post_reset");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic r;
      v = rnd_in();
      r = ($urandom_range(0, 39) == 0);
      model(v, r);
      step(v, r, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
